ysyx_22050499_icache_assoc: RTL
===============================

# ysyx_22050499_icache_assoc

Parametrised set-associative instruction cache, successor to the direct-mapped single-word ICACHE. Sits between the IFU and the SDRAM/AXI bridge. Serves 32-bit instruction fetches through a valid/ready request/response pair, refills whole lines from memory in one wide beat, and replaces per set with round-robin. Supports `fence_i` invalidation at any time, including during an outstanding refill.

## Interface
Parameters:
- `WAYS`, 2: associativity; legal values 1, 2, 4.
- `SETS`, 8: sets per way; power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, at least 1.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `fence_i` in 1: one-cycle pulse; invalidates all lines.
- `req_valid` in 1: fetch request.
- `req_ready` out 1: cache accepts a request; high only in IDLE.
- `req_addr` in 32: fetch address; bits [1:0] ignored.
- `rsp_valid` out 1: instruction available.
- `rsp_ready` in 1: IFU accepts the response.
- `rsp_data` out 32: instruction word.
- `mem_req_valid` out 1: line refill request.
- `mem_req_ready` in 1: memory accepts the refill request.
- `mem_req_addr` out 32: line-aligned refill address.
- `mem_rvalid` in 1: refill data valid; one beat per line.
- `mem_rdata` in 32*LINE_WORDS: refill line; lowest-address word in the MSBs.
- `perf_hit`, `perf_miss` out 32: performance counters (see Configuration).

## Operation
Address split:
- offset = `req_addr[log2(LINE_WORDS)+1:2]`
- index = next log2(SETS) bits
- tag = remaining upper bits

Per way and set: one valid bit, one tag, and LINE_WORDS words. Per set: one round-robin pointer of log2(WAYS) bits.

State machine:
- IDLE: `req_ready` = 1. On `req_valid`, register the address and go to LOOKUP.
- LOOKUP: compare tags across all ways.
  - Hit (at most one way matches): `rsp_valid` = 1 and `rsp_data` = the hit word.
  - Hit with `rsp_ready` = 1: go to IDLE. Hit with `rsp_ready` = 0: hold the response stable in LOOKUP.
  - Miss: go to REFILL_REQ.
- REFILL_REQ: hold `mem_req_valid` high with `mem_req_addr` = {tag, index, 0...}. On `mem_req_ready`, go to REFILL_WAIT.
- REFILL_WAIT: on `mem_rvalid`:
  - Write the line into the victim way: the first invalid way (lowest number), otherwise the way at the set's round-robin pointer.
  - Set valid and tag for that way.
  - Advance the set's pointer modulo WAYS, but only when a valid line was evicted.
  - Latch the requested word and go to RESP.
- RESP: `rsp_valid` = 1 with the latched word. On `rsp_ready`, go to IDLE.

fence_i rules:
- Clears every valid bit on the next edge. Round-robin pointers are also cleared.
- If it arrives in REFILL_REQ or REFILL_WAIT, a `drop` flag is set. The returning line is still delivered to the IFU but not installed (valid stays 0). `drop` clears on leaving RESP.
- If `fence_i` coincides with `mem_rvalid`, the line is dropped.

Reset:
- Clears valid bits, pointers, `drop`, counters and state (state returns to IDLE).
- Reset mid-refill abandons the transaction. A stale `mem_rvalid` that arrives in IDLE or LOOKUP is ignored.

## Timing
Reset values:
- `req_ready` = 1
- `rsp_valid` = 0
- `rsp_data` = 0
- `mem_req_valid` = 0
- `mem_req_addr` = 0
- counters = 0

Latency:
- Hit: request accepted at edge T; `rsp_valid` high during cycle T+1 (combinational read of the arrays using the registered address).
- Miss: `mem_req_valid` rises in cycle T+2. `rsp_valid` rises the cycle after `mem_rvalid`.

Rules:
- One outstanding request; no hit-under-miss.
- `rsp_data` stays stable while `rsp_valid` is high and `rsp_ready` is low.
- `mem_req_addr` stays stable while `mem_req_valid` is high.

## Configuration
- `ICACHE_PERF_EN` defined:
  - `perf_hit` increments on each hit response handshake.
  - `perf_miss` increments on each `mem_req_valid` && `mem_req_ready`.
  - Both are 32-bit and wrap. `fence_i` does not clear them.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared constants go in the common macros header: state encodings (IDLE=0, LOOKUP=1, REFILL_REQ=2, REFILL_WAIT=3, RESP=4) and derived widths (OFF_W, IDX_W, TAG_W).
- One sub-module, `ysyx_22050499_icache_way`, is instantiated WAYS times. It holds valid/tag/data for SETS lines and has:
  - read port: index → valid, tag, word at offset
  - write port: whole line + tag
  - bulk-invalidate input

## Test plan
- Cold miss: WAYS=2, SETS=8, LINE_WORDS=4; fetch 0x8000_0010. Expect `mem_req_addr` = 0x8000_0010. Return 0x11111111_22222222_33333333_44444444; `rsp_data` = 0x11111111. A following fetch of 0x8000_0018 hits in 1 cycle and returns 0x33333333.
- Conflict/replacement: fetch 0x8000_0000, 0x8000_0080, 0x8000_0100 (all set 0). Expect three misses; the third evicts way 0. Re-fetching 0x8000_0080 hits; re-fetching 0x8000_0000 misses.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles on a hit. `rsp_valid` and `rsp_data` stay constant and `req_ready` = 0 throughout.
- fence_i during REFILL_WAIT: the line is delivered to the IFU. A re-fetch of the same address misses again.
- Memory stall: hold `mem_req_ready` = 0 for 7 cycles. `mem_req_valid` and `mem_req_addr` stay stable, and exactly one request is issued.
- Reset asserted in REFILL_WAIT, then a late `mem_rvalid`: state is IDLE, no response is produced, no line is installed. With `ICACHE_PERF_EN` defined, counters = 0.

Source files
------------

// File: rtl/ysyx_22050499_icache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache:
// FSM state encoding and width helpers used to derive OFF_W / IDX_W / TAG_W.
package ysyx_22050499_icache_assoc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOOKUP      = 3'd1,
        ST_REFILL_REQ  = 3'd2,
        ST_REFILL_WAIT = 3'd3,
        ST_RESP        = 3'd4
    } state_t;

    // Width of a field that selects among n items (n is a power of two).
    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Same, but never zero so it can size a vector.
    function automatic int unsigned vec_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ysyx_22050499_icache_way.sv
// One way of the instruction cache: valid bits, tags and line data for
// SETS lines. Asynchronous read by index/offset, whole-line write, and a
// bulk invalidate that clears every valid bit on the next edge.
module ysyx_22050499_icache_way
    import ysyx_22050499_icache_assoc_pkg::*;
#(
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 3,
    parameter int OFF_VW     = 2,
    parameter int TAG_W      = 25
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inval,
    input  logic [IDX_W-1:0]         rd_idx,
    input  logic [OFF_VW-1:0]        rd_off,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [31:0]              rd_word,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [32*LINE_WORDS-1:0] wr_line
);

    localparam int LINE_W = 32 * LINE_WORDS;

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];
    logic [LINE_W-1:0] rd_line;
    logic [31:0]       rd_words [LINE_WORDS];

    // Valid bits: cleared by reset or invalidate, set when a line is written.
    always_ff @(posedge clock) begin
        if (reset || inval) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

    // Lowest-address word sits in the MSBs of the line.
    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_split
        assign rd_words[k] = rd_line[LINE_W-1-32*k -: 32];
    end

    assign rd_word = rd_words[rd_off];

endmodule

// File: rtl/ysyx_22050499_icache_assoc.sv
// Set-associative instruction cache with round-robin replacement and
// single-beat line refill. Optional performance counters are built only
// when ICACHE_PERF_EN is defined; otherwise perf_hit/perf_miss read 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until that edge.
module ysyx_22050499_icache_assoc
    import ysyx_22050499_icache_assoc_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fence_i,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [31:0]              mem_req_addr,
    input  logic                     mem_rvalid,
    input  logic [32*LINE_WORDS-1:0] mem_rdata,
    output logic [31:0]              perf_hit,
    output logic [31:0]              perf_miss,
    output logic [2:0]               dbg_state
);

    localparam int OFF_W  = sel_w(LINE_WORDS);
    localparam int OFF_VW = vec_w(LINE_WORDS);
    localparam int IDX_W  = sel_w(SETS);
    localparam int TAG_W  = 32 - 2 - OFF_W - IDX_W;
    localparam int PTR_W  = vec_w(WAYS);
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4 - 1));

    state_t state, state_nxt;

    logic [31:0]       addr_q;
    logic [TAG_W-1:0]  tag_a;
    logic [IDX_W-1:0]  idx_a;
    logic [OFF_VW-1:0] off_a;
    logic [31:0]       rsp_word_q;
    logic              drop_q;

    logic [WAYS-1:0]             way_valid;
    logic [WAYS-1:0]             hit_vec;
    logic [WAYS-1:0]             way_wr;
    logic [TAG_W-1:0]            way_tag  [WAYS];
    logic [WAYS-1:0][31:0]       way_word;
    logic [SETS-1:0][PTR_W-1:0]  rr_q;
    logic [PTR_W-1:0]            victim;
    logic                        all_valid;
    logic                        hit;
    logic [31:0]                 hit_word;
    logic [31:0]                 fill_words [LINE_WORDS];

    logic fire_hit, mem_fire, fill, install;

    // Address fields of the registered request.
    assign off_a = (OFF_W == 0) ? '0 : OFF_VW'(addr_q >> 2);
    assign idx_a = IDX_W'(addr_q >> (2 + OFF_W));
    assign tag_a = TAG_W'(addr_q >> (2 + OFF_W + IDX_W));

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        ysyx_22050499_icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .IDX_W      (IDX_W),
            .OFF_VW     (OFF_VW),
            .TAG_W      (TAG_W)
        ) u_way (
            .clock    (clock),
            .reset    (reset),
            .inval    (fence_i),
            .rd_idx   (idx_a),
            .rd_off   (off_a),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_word  (way_word[w]),
            .wr_en    (way_wr[w]),
            .wr_idx   (idx_a),
            .wr_tag   (tag_a),
            .wr_line  (mem_rdata)
        );
        assign hit_vec[w] = way_valid[w] && (way_tag[w] == tag_a);
        assign way_wr[w]  = install && (victim == PTR_W'(w));
    end

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_fill
        assign fill_words[k] = mem_rdata[LINE_W-1-32*k -: 32];
    end

    assign hit       = |hit_vec;
    assign all_valid = &way_valid;

    // Hit word: OR of the matching way (at most one matches).
    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_word = hit_word | way_word[w];
        end
    end

    // Victim: lowest-numbered invalid way, else the set's round-robin pointer.
    always_comb begin
        victim = rr_q[idx_a];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim = PTR_W'(w);
        end
    end

    assign fire_hit = (state == ST_LOOKUP) && hit && rsp_ready;
    assign mem_fire = (state == ST_REFILL_REQ) && mem_req_ready;
    assign fill     = (state == ST_REFILL_WAIT) && mem_rvalid;
    assign install  = fill && !drop_q && !fence_i;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:        if (req_valid) state_nxt = ST_LOOKUP;
            ST_LOOKUP: begin
                if (!hit)           state_nxt = ST_REFILL_REQ;
                else if (rsp_ready) state_nxt = ST_IDLE;
            end
            ST_REFILL_REQ:  if (mem_req_ready) state_nxt = ST_REFILL_WAIT;
            ST_REFILL_WAIT: if (mem_rvalid)    state_nxt = ST_RESP;
            ST_RESP:        if (rsp_ready)     state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; idle values are all zero except req_ready.
    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        case (state)
            ST_IDLE:       req_ready = 1'b1;
            ST_LOOKUP: begin
                rsp_valid = hit;
                rsp_data  = hit ? hit_word : '0;
            end
            ST_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q & LINE_MASK;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = rsp_word_q;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

    // Request address capture and refill word latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            rsp_word_q <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) addr_q <= req_addr;
            if (fill) rsp_word_q <= fill_words[off_a];
        end
    end

    // A fence seen while a refill is outstanding keeps the returning line
    // out of the arrays; the flag lives until the response is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_q <= 1'b0;
        end else if (fence_i && (state == ST_REFILL_REQ || state == ST_REFILL_WAIT)) begin
            drop_q <= 1'b1;
        end else if (state == ST_RESP && rsp_ready) begin
            drop_q <= 1'b0;
        end
    end

    // Round-robin pointers advance only when a valid line is evicted.
    always_ff @(posedge clock) begin
        if (reset || fence_i) begin
            rr_q <= '0;
        end else if (install && all_valid) begin
            rr_q[idx_a] <= (rr_q[idx_a] == PTR_W'(WAYS - 1)) ? '0 : rr_q[idx_a] + 1'b1;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Hit and refill-request counters; wrap naturally, unaffected by fence_i.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (fire_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (mem_fire) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign perf_hit  = hit_cnt_q;
    assign perf_miss = miss_cnt_q;
`else
    logic perf_unused;
    assign perf_unused = fire_hit ^ mem_fire;
    assign perf_hit    = '0;
    assign perf_miss   = '0;
`endif

endmodule
